// File: rtl/core_pkg.sv
// core_pkg: shared constants and FSM state type for the register dump reader
package core_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  localparam int NUM_ARCH_REGS = 32;
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, DONE} regdump_state_t;
endpackage

// File: rtl/regfile_dump_reader_if.sv
// regfile_dump_reader_if: valid/ready beat stream carrying {index, data, last, csum}
interface regfile_dump_reader_if import core_pkg::*; #(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_csum;
  modport master (output out_valid, out_index, out_data, out_last, out_csum, input out_ready);
  modport slave (input out_valid, out_index, out_data, out_last, out_csum, output out_ready);
endinterface

// File: rtl/regdump_beat_reg.sv
// regdump_beat_reg: output beat holding register; loads a beat, holds it while stalled, drops it on clear
module regdump_beat_reg import core_pkg::*; #(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_i,
  input  logic                  clr_i,
  input  logic [ADDR_W-1:0]     index_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic                  last_i,
  input  logic                  csum_i,
  regfile_dump_reader_if.master dump
);
  logic              valid_q, last_q, csum_q;
  logic [ADDR_W-1:0] index_q;
  logic [DATA_W-1:0] data_q;
  // load wins over clear so a checksum beat can replace the accepted last register beat
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      valid_q <= 1'b0;
      index_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      csum_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      index_q <= index_i;
      data_q  <= data_i;
      last_q  <= last_i;
      csum_q  <= csum_i;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      csum_q  <= 1'b0;
    end
  assign dump.out_valid = valid_q;
  assign dump.out_index = index_q;
  assign dump.out_data  = data_q;
  assign dump.out_last  = last_q;
  assign dump.out_csum  = csum_q;
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: streams every register as {index, data} beats; REGDUMP_CHECKSUM_EN appends an XOR checksum beat
module regfile_dump_reader import core_pkg::*; #(
  parameter int DATA_W   = XLEN,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = NUM_ARCH_REGS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  regfile_dump_reader_if.master dump,
  output logic                  busy,
  output logic                  done
);
  regdump_state_t    state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q, done_q;
  logic              hs, last_reg, csum_beat, load, clr, ld_last;
  logic [DATA_W-1:0] csum_data, ld_data;
  logic [ADDR_W-1:0] ld_idx;
  assign hs       = dump.out_valid & dump.out_ready;
  assign last_reg = cnt_q == ADDR_W'(NUM_REGS - 1);
`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
  logic [DATA_W-1:0] acc_q;
  // XOR of every register value latched during this dump
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) acc_q <= '0;
    else if (state_q == IDLE && start) acc_q <= '0;
    else if (state_q == READ) acc_q <= acc_q ^ rd_data;
  assign csum_beat = state_q == SEND && hs && last_reg && !abort;
  assign csum_data = acc_q;
`else
  localparam bit CSUM_EN = 1'b0;
  assign csum_beat = 1'b0;
  assign csum_data = '0;
`endif
  assign load    = !abort && (state_q == READ || csum_beat);
  assign clr     = abort || (hs && (state_q == SEND || state_q == CSUM));
  assign ld_idx  = csum_beat ? '0 : cnt_q;
  assign ld_data = csum_beat ? csum_data : rd_data;
  assign ld_last = csum_beat || (!CSUM_EN && last_reg);
  assign rd_addr = cnt_q;
  assign busy    = busy_q;
  assign done    = done_q;
  // dump sequencer; abort from any state returns to IDLE with the counter cleared
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
      end else
        case (state_q)
          IDLE: if (start) begin
            state_q <= READ;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
          READ: state_q <= SEND;
          SEND: if (hs) begin
            if (!last_reg) begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= READ;
            end else begin
              state_q <= CSUM_EN ? CSUM : DONE;
              done_q  <= !CSUM_EN;
            end
          end
          CSUM: if (hs) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
          DONE: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
    end
  regdump_beat_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_beat (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (load),
    .clr_i   (clr),
    .index_i (ld_idx),
    .data_i  (ld_data),
    .last_i  (ld_last),
    .csum_i  (csum_beat),
    .dump    (dump)
  );
endmodule

// File: tb/tb_regfile_dump_reader.sv
// tb_regfile_dump_reader: scoreboard bench for the register dump reader
module tb_regfile_dump_reader;
  localparam int DW = 32, AW = 5, NR = 32;
`ifdef REGDUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  typedef struct packed {logic [AW-1:0] idx; logic [DW-1:0] data; logic last; logic csum;} beat_t;
  logic clk = 0, resetn = 1, start = 0, abort = 0;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic busy, done;
  logic [DW-1:0] regs [NR];
  logic rnd_mode = 0, rnd_bit = 0, ready_val = 1, hold = 0;
  int total = 0, bad = 0, n = 0;
  beat_t sb [$];

  regfile_dump_reader_if #(.DATA_W(DW), .ADDR_W(AW)) dif ();
  regfile_dump_reader #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .rd_addr(rd_addr), .rd_data(rd_data), .dump(dif), .busy(busy), .done(done));

  assign rd_data = regs[rd_addr];
  assign dif.out_ready = hold ? 1'b0 : (rnd_mode ? rnd_bit : ready_val);
  always #5 clk = ~clk;
  always @(posedge clk) begin #1; rnd_bit = 1'($urandom_range(0, 1)); end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor: every accepted beat must be the next one the reference predicted
  always @(negedge clk) if (resetn) begin
    if (dif.out_last) chk("last_with_valid", 64'(dif.out_valid), 64'd1);
    if (dif.out_valid && dif.out_ready) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_beat: got index %0d, want no beat", dif.out_index);
      end else chk("beat", 64'({dif.out_index, dif.out_data, dif.out_last, dif.out_csum}), 64'(sb.pop_front()));
    end
  end

  task automatic preload();
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;
  endtask

  // reference: a dump is the register snapshot in index order, then optionally the XOR of all of them
  task automatic push_dump();
    logic [DW-1:0] x = '0;
    for (int i = 0; i < NR; i++) begin
      beat_t b;
      b.idx = AW'(i); b.data = regs[i]; b.last = (CS == 0) && (i == NR - 1); b.csum = 1'b0;
      x ^= regs[i];
      sb.push_back(b);
    end
    if (CS != 0) sb.push_back('{idx: '0, data: x, last: 1'b1, csum: 1'b1});
  endtask

  task automatic start_dump();
    push_dump();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 500) begin @(posedge clk); #1; cyc++; end
    if (!done) begin total++; bad++; $display("FAIL done_timeout: got done=0, want done=1"); end
    @(posedge clk); #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("queue_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_addr(int a);
    int t = 0;
    while (rd_addr != AW'(a) && t < 300) begin @(posedge clk); #1; t++; end
    if (rd_addr != AW'(a)) begin total++; bad++; $display("FAIL addr_timeout: got %0d want %0d", rd_addr, a); end
  endtask

  task automatic wait_beat(int a);
    int t = 0;
    while (!(dif.out_valid && dif.out_index == AW'(a)) && t < 300) begin @(posedge clk); #1; t++; end
    if (!dif.out_valid) begin total++; bad++; $display("FAIL beat_timeout: got valid=0 want beat %0d", a); end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = '0;
    #1 resetn = 0;
    #1;
    chk("reset_outputs", 64'({dif.out_valid, dif.out_index, dif.out_data, dif.out_last, dif.out_csum, busy, done, rd_addr}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1;
    @(posedge clk); #1;

    // full dump with constant ready and exact latency
    preload();
    start_dump();
    chk("busy_running", 64'(busy), 64'd1);
    wait_done(n);
    chk("latency", 64'(n), 64'(2 * NR + 1 + CS));

    // random backpressure, regfile overwritten under a stalled beat
    preload();
    rnd_mode = 1;
    start_dump();
    wait_addr(5);
    hold = 1;
    wait_beat(5);
    regs[5] = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk); #1;
    chk("stall_frozen", 64'(dif.out_data), 64'h1000_0005);
    hold = 0;
    wait_done(n);
    rnd_mode = 0;

    // abort while beat 10 is stalled
    preload();
    start_dump();
    wait_addr(10);
    hold = 1;
    wait_beat(10);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_valid", 64'(dif.out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    sb.delete();
    hold = 0;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(posedge clk); #1;
    end
    start_dump();
    wait_done(n);

    // start during a dump is ignored
    preload();
    start_dump();
    wait_addr(3);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_done(n);

    // start and abort together in IDLE
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    chk("start_abort_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk); #1;
    chk("start_abort_idle", 64'({busy, dif.out_valid}), 64'd0);

    // randomized register contents with random backpressure
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      rnd_mode = 1;
      start_dump();
      wait_done(n);
      rnd_mode = 0;
    end

    // checksum pattern
    for (int i = 0; i < NR; i++) regs[i] = '0;
    regs[1] = 32'hF0F0_F0F0;
    regs[2] = 32'h0F0F_0F0F;
    start_dump();
    wait_done(n);

    // asynchronous reset mid-beat
    preload();
    hold = 1;
    start_dump();
    wait_beat(0);
    #3 resetn = 0;
    #1;
    chk("async_reset", 64'({dif.out_valid, dif.out_index, dif.out_data, dif.out_last, dif.out_csum, busy, done, rd_addr}), 64'd0);
    sb.delete();
    hold = 0;
    @(negedge clk) resetn = 1;
    repeat (2) @(posedge clk); #1;
    chk("post_reset_idle", 64'({busy, dif.out_valid}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end
endmodule
